// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module     : data_sram_responder
// Description: MEM-stage data-RAM responder. Byte-lane writes and word reads
//              on a word-organised SRAM with optional wait states.
// Revision   : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        range_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Bits [31:29] are segment aliases and are excluded from the range check.
  localparam logic [31:0] c_range_mask =
      32'h1FFF_FFFF & ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);
  localparam logic       c_no_wait   = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  w_in_wait;
  logic                  w_complete;
  logic [3:0]            w_sel;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;

  // While waiting, the latched request is the one that completes.
  assign w_in_wait  = (r_state == S_WAIT);
  assign w_sel      = w_in_wait ? r_sel   : req_sel;
  assign w_addr     = w_in_wait ? r_addr  : req_addr;
  assign w_wdata    = w_in_wait ? r_wdata : req_wdata;
  assign w_complete = w_in_wait ? (r_cnt == 4'd0) : (req_en & c_no_wait);
  assign w_in_range = ((w_addr & c_range_mask) == 32'd0);
  assign w_idx      = w_addr[ADDR_WIDTH+1:2];
  assign stall      = req_en & ~w_complete;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_sel      <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      range_err  <= 1'b0;
    end else begin
      resp_valid <= w_complete;
      range_err  <= w_complete & ~w_in_range;
      resp_rdata <= (w_complete && w_in_range && (w_sel == 4'd0)) ? mem[w_idx] : 32'd0;
      case (r_state)
        S_IDLE: begin
          if (req_en && !c_no_wait) begin
            r_sel   <= req_sel;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= c_wait_init;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset suppresses the write so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (rst && w_complete && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (w_sel[i]) mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// Bench for data_sram_responder: a zero-wait and a three-wait instance checked
// against a word-map model using vector tables, hand sequences and random traffic.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_en, a_stall, a_valid, a_err;
  logic [3:0]  a_sel;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_en, b_stall, b_valid, b_err;
  logic [3:0]  b_sel;
  logic [31:0] b_addr, b_wdata, b_rdata;

  data_sram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .req_en(a_en), .req_sel(a_sel), .req_addr(a_addr),
    .req_wdata(a_wdata), .stall(a_stall), .resp_valid(a_valid),
    .resp_rdata(a_rdata), .range_err(a_err));

  data_sram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .req_en(b_en), .req_sel(b_sel), .req_addr(b_addr),
    .req_wdata(b_wdata), .stall(b_stall), .resp_valid(b_valid),
    .resp_rdata(b_rdata), .range_err(b_err));

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];

  typedef struct {
    logic        en;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;
  vec_t tbl [17];

  function automatic bit in_rng(logic [31:0] addr);
    return addr[28:14] == 15'd0;
  endfunction

  function automatic int widx(logic [31:0] addr);
    return int'(addr[13:2]);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] sel, logic [31:0] wd);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait instance: one request per cycle, response one cycle later.
  task automatic a_apply(logic en, logic [3:0] sel, logic [31:0] addr, logic [31:0] wd,
                         logic exp_v, logic [31:0] exp_d, logic exp_e);
    a_en = en; a_sel = sel; a_addr = addr; a_wdata = wd;
    #1 chk("a_stall", a_stall, 0);
    tick();
    chk("a_valid", a_valid, exp_v);
    chk("a_err", a_err, exp_e);
    if (exp_v) chk("a_rdata", a_rdata, exp_d);
    if (en && in_rng(addr) && sel != 4'd0)
      mdl_a[widx(addr)] = merge(mdl_a.exists(widx(addr)) ? mdl_a[widx(addr)] : 32'hx, sel, wd);
  endtask

  // Three-wait instance: stall for cycles T..T+2, response visible at T+4.
  task automatic b_access(logic [3:0] sel, logic [31:0] addr, logic [31:0] wd,
                          logic [31:0] exp_d, logic exp_e);
    b_en = 1'b1; b_sel = sel; b_addr = addr; b_wdata = wd;
    for (int k = 0; k < 4; k++) begin
      #1 chk("b_stall", b_stall, (k < 3) ? 32'd1 : 32'd0);
      tick();
      if (k < 3) chk("b_valid_early", b_valid, 0);
    end
    chk("b_valid", b_valid, 1);
    chk("b_err", b_err, exp_e);
    chk("b_rdata", b_rdata, exp_d);
    b_en = 1'b0;
    if (in_rng(addr) && sel != 4'd0)
      mdl_b[widx(addr)] = merge(mdl_b.exists(widx(addr)) ? mdl_b[widx(addr)] : 32'hx, sel, wd);
  endtask

  function automatic logic [31:0] rnd_addr(bit oor, int idx);
    logic [31:0] ad;
    if (oor) ad = $urandom | (32'd1 << $urandom_range(14, 28));
    else     ad = {3'($urandom), 15'd0, 12'(idx), 2'b00};
    return ad;
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 4'h0, 32'hA000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b1, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 4'h4, 32'h0000_0020, 32'h00AA_0000, 1'b1, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h11AA_3344, 1'b0};
    tbl[5]  = '{1'b1, 4'h3, 32'h0000_0020, 32'h0000_5566, 1'b1, 32'h0,         1'b0};
    tbl[6]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h11AA_5566, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[8]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 32'h0,         1'b0};
    tbl[9]  = '{1'b1, 4'h0, 32'h0000_4000, 32'h0,         1'b1, 32'h0,         1'b1};
    tbl[10] = '{1'b1, 4'hF, 32'h0000_4000, 32'h1234_5678, 1'b1, 32'h0,         1'b1};
    tbl[11] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 32'hE000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[13] = '{1'b1, 4'hF, 32'h0000_3FFC, 32'hA5A5_5A5A, 1'b1, 32'h0,         1'b0};
    tbl[14] = '{1'b1, 4'h0, 32'h8000_3FFC, 32'h0,         1'b1, 32'hA5A5_5A5A, 1'b0};
    tbl[15] = '{1'b1, 4'h0, 32'h1000_0000, 32'h0,         1'b1, 32'h0,         1'b1};
    tbl[16] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};

    rst = 1'b0;
    a_en = 0; a_sel = 0; a_addr = 0; a_wdata = 0;
    b_en = 0; b_sel = 0; b_addr = 0; b_wdata = 0;
    tick(); tick();
    chk("rst_a_valid", a_valid, 0); chk("rst_a_rdata", a_rdata, 0); chk("rst_a_err", a_err, 0);
    chk("rst_b_valid", b_valid, 0); chk("rst_b_rdata", b_rdata, 0); chk("rst_b_err", b_err, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 17; i++)
      a_apply(tbl[i].en, tbl[i].sel, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_v, tbl[i].exp_d, tbl[i].exp_e);

    // Reset held with a live write: no response, no write.
    a_en = 1; a_sel = 4'hF; a_addr = 32'h0000_0020; a_wdata = 32'hFFFF_FFFF;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rsthold_valid", a_valid, 0); chk("rsthold_rdata", a_rdata, 0); chk("rsthold_err", a_err, 0);
    end
    rst = 1'b1; a_en = 0;
    tick();
    a_apply(1, 4'h0, 32'h0000_0020, 0, 1, 32'h11AA_5566, 0);

    // Random traffic on the zero-wait instance.
    for (int i = 0; i < 16; i++) a_apply(1, 4'hF, rnd_addr(0, 64 + i), $urandom, 1, 0, 0);
    for (int n = 0; n < 200; n++) begin
      int op = $urandom_range(0, 9);
      int idx = 64 + $urandom_range(0, 15);
      logic [3:0] sel = 4'($urandom);
      logic [31:0] ad = rnd_addr(op == 0, idx);
      if (op == 1)      a_apply(0, sel, ad, $urandom, 0, 0, 0);
      else if (op == 0) a_apply(1, sel, ad, $urandom, 1, 0, 1);
      else              a_apply(1, sel, ad, $urandom, 1, (sel == 0) ? mdl_a[idx] : 32'd0, 0);
    end
    a_en = 0;

    // Wait-state instance: timing, back-to-back, range.
    b_access(4'hF, 32'h8000_0100, 32'h1357_9BDF, 0, 0);
    b_access(4'h0, 32'hA000_0100, 0, 32'h1357_9BDF, 0);
    b_access(4'h2, 32'h0000_0100, 32'h0000_EE00, 0, 0);
    b_access(4'h0, 32'h0000_0100, 0, 32'h1357_EEDF, 0);
    b_access(4'h0, 32'h0000_4000, 0, 0, 1);
    tick();
    chk("b_idle_valid", b_valid, 0);

    // Reset one cycle into a waited write aborts it.
    b_access(4'hF, 32'h0000_0040, 32'h0BAD_F00D, 0, 0);
    b_en = 1; b_sel = 4'hF; b_addr = 32'h0000_0040; b_wdata = 32'hFFFF_0000;
    #1 chk("b_abort_stall", b_stall, 1);
    tick();
    rst = 1'b0; b_en = 0;
    tick();
    chk("b_abort_valid", b_valid, 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b_post_rst_valid", b_valid, 0);
    end
    b_access(4'h0, 32'h0000_0040, 0, 32'h0BAD_F00D, 0);

    for (int i = 0; i < 8; i++) b_access(4'hF, rnd_addr(0, 64 + i), $urandom, 0, 0);
    for (int n = 0; n < 30; n++) begin
      int idx = 64 + $urandom_range(0, 7);
      bit oor = ($urandom_range(0, 5) == 0);
      logic [3:0] sel = 4'($urandom);
      logic [31:0] ad = rnd_addr(oor, idx);
      if (oor) b_access(sel, ad, $urandom, 0, 1);
      else     b_access(sel, ad, $urandom, (sel == 0) ? mdl_b[idx] : 32'd0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
